// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM/IO port shared by fetch, load and store (MEM_ARB_RR_EN: load/fetch round-robin)
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  output logic [DATA_W-1:0] fetch_inst,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [1:0]        load_size,
  input  logic              load_signed,
  output logic              load_done,
  output logic [DATA_W-1:0] load_data,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [1:0]        store_size,
  input  logic [DATA_W-1:0] store_data,
  output logic              store_done,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef enum logic [1:0] {G_NONE, G_FETCH, G_LOAD, G_STORE} grant_t;
  state_t state, state_n;
  grant_t grant;
  logic [ADDR_W-1:0] addr, req_addr;
  logic [1:0] size;
  logic sgn, src_load, wr, rdy_d, s_ok, l_ok, f_ok, io, io_new, io_block;
  logic [2:0] c, n;
  logic [7:0] hold_b, din;
  logic [DATA_W-1:0] asm_q, asm_n, ext;
`ifdef MEM_ARB_RR_EN
  logic last_load;
`endif
  assign mem_wr = wr & rdy;
  assign n = size == 2'b00 ? 3'd1 : size == 2'b01 ? 3'd2 : 3'd4;
  assign io = addr[17:16] == IO_HI;
  assign io_new = store_addr[17:16] == IO_HI;
  assign io_block = io_new & io_buffer_full;
  assign req_addr = grant == G_STORE ? store_addr : grant == G_LOAD ? load_addr : fetch_addr;
  // The RAM keeps reading while paused, so the byte in flight when rdy fell is replayed on resume
  assign din = rdy_d ? mem_din : hold_b;
  // Pick a requester; one whose done is showing this cycle is masked, and clear blocks reads
  always_comb begin
    s_ok = store_req & ~store_done;
    l_ok = load_req & ~load_done & ~clear;
    f_ok = fetch_req & ~fetch_done & ~clear;
`ifdef MEM_ARB_RR_EN
    grant = s_ok ? G_STORE : (l_ok && !(f_ok && last_load)) ? G_LOAD : f_ok ? G_FETCH : G_NONE;
`else
    grant = s_ok ? G_STORE : l_ok ? G_LOAD : f_ok ? G_FETCH : G_NONE;
`endif
  end
  // Merge the incoming byte into the little-endian word and extend it
  always_comb begin
    asm_n = asm_q;
    if (c != 3'd0) asm_n[{c[1:0] - 2'd1, 3'b000} +: 8] = din;
    ext = size == 2'b00 ? {{(DATA_W-8){sgn & asm_n[7]}}, asm_n[7:0]}
        : size == 2'b01 ? {{(DATA_W-16){sgn & asm_n[15]}}, asm_n[15:0]} : asm_n;
  end
  // Next state: reads end on clear or after the last byte, writes always finish
  always_comb
    state_n = state == IDLE ? (grant == G_STORE ? WRITE : grant == G_NONE ? IDLE : READ)
            : state == READ ? ((clear || c == n) ? IDLE : READ)
            : (c == n ? IDLE : WRITE);
  // State register, frozen while rdy is low
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else if (rdy) state <= state_n;
  // Track rdy and capture the byte that arrives in the first paused cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdy_d <= 1'b1;
      hold_b <= '0;
    end else begin
      rdy_d <= rdy;
      if (rdy_d && !rdy) hold_b <= mem_din;
    end
`ifdef MEM_ARB_RR_EN
  // Remember which of load/fetch was granted last
  always_ff @(posedge clk or posedge rst)
    if (rst) last_load <= 1'b0;
    else if (rdy && state == IDLE && (grant == G_LOAD || grant == G_FETCH)) last_load <= grant == G_LOAD;
`endif
  // Byte sequencing: c counts read cycles in READ and issued bytes in WRITE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      size <= '0;
      sgn <= 1'b0;
      src_load <= 1'b0;
      c <= '0;
      asm_q <= '0;
      wr <= 1'b0;
      mem_a <= '0;
      mem_dout <= '0;
      fetch_done <= 1'b0;
      fetch_inst <= '0;
      load_done <= 1'b0;
      load_data <= '0;
      store_done <= 1'b0;
    end else if (rdy) begin
      fetch_done <= 1'b0;
      load_done <= 1'b0;
      store_done <= 1'b0;
      if (state == IDLE) begin
        if (grant != G_NONE) begin
          addr <= req_addr;
          mem_a <= req_addr;
          size <= grant == G_STORE ? store_size : grant == G_LOAD ? load_size : 2'b10;
          sgn <= load_signed;
          src_load <= grant == G_LOAD;
        end
        wr <= grant == G_STORE && !io_block;
        mem_dout <= grant == G_STORE ? store_data[7:0] : mem_dout;
        c <= (grant == G_STORE && !io_block) ? 3'd1 : 3'd0;
      end else if (state == READ) begin
        if (!clear) begin
          c <= c + 3'd1;
          asm_q <= asm_n;
          if (c + 3'd1 < n) mem_a <= addr + ADDR_W'(c + 3'd1);
          if (c == n) begin
            load_done <= src_load;
            fetch_done <= !src_load;
            if (src_load) load_data <= ext;
            else fetch_inst <= asm_n;
          end
        end
      end else if (c == n) begin
        wr <= 1'b0;
        store_done <= 1'b1;
      end else if (io && (wr || io_buffer_full)) begin
        wr <= 1'b0;
      end else begin
        wr <= 1'b1;
        mem_a <= addr + ADDR_W'(c);
        mem_dout <= store_data[{c[1:0], 3'b000} +: 8];
        c <= c + 3'd1;
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a byte RAM model
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, clear = 1'b0;
  logic fetch_req = 1'b0, load_req = 1'b0, load_signed = 1'b0, store_req = 1'b0, io_buffer_full = 1'b0;
  logic [31:0] fetch_addr = '0, load_addr = '0, store_addr = '0, store_data = '0;
  logic [1:0] load_size = '0, store_size = '0;
  logic fetch_done, load_done, store_done, mem_wr;
  logic [31:0] fetch_inst, load_data, mem_a;
  logic [7:0] mem_din = '0, mem_dout;
  logic [7:0] ram [0:1023];
  logic [31:0] a_log [0:63];
  logic w_log [0:63];
  logic [7:0] d_log [0:63];
  int pass_cnt = 0, total_cnt = 0;
  int sd, ld, fd, e_ld, e_fd;
  int clr_on = -10, clr_off = -10, rdy_off = -10, rdy_on = -10, io_rel = -10;
  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done), .fetch_inst(fetch_inst),
    .load_req(load_req), .load_addr(load_addr), .load_size(load_size), .load_signed(load_signed),
    .load_done(load_done), .load_data(load_data),
    .store_req(store_req), .store_addr(store_addr), .store_size(store_size), .store_data(store_data),
    .store_done(store_done), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );
  always #5 clk = ~clk;
  // RAM with one cycle read latency; reads continue regardless of rdy
  always @(posedge clk) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic int wcount(input int ncyc);
    int s = 0;
    for (int i = 1; i <= ncyc; i++) s += int'(w_log[i]);
    return s;
  endfunction
  task automatic run(input int ncyc);
    sd = -1; ld = -1; fd = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      if (k == clr_on) begin clear = 1'b1; load_req = 1'b0; fetch_req = 1'b0; end
      if (k == clr_off) clear = 1'b0;
      if (k == rdy_off) rdy = 1'b0;
      if (k == rdy_on) rdy = 1'b1;
      if (k == io_rel) io_buffer_full = 1'b0;
      #1;
      a_log[k] = mem_a; w_log[k] = mem_wr; d_log[k] = mem_dout;
      if (store_done && sd < 0) begin sd = k; store_req = 1'b0; end
      if (load_done && ld < 0) begin ld = k; load_req = 1'b0; end
      if (fetch_done && fd < 0) begin fd = k; fetch_req = 1'b0; end
    end
    clr_on = -10; clr_off = -10; rdy_off = -10; rdy_on = -10; io_rel = -10;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
    ram[10'h200] = 8'h80; ram[10'h204] = 8'h34; ram[10'h205] = 8'hF2;
    ram[10'h3FF] = 8'h11; ram[10'h000] = 8'h22; ram[10'h001] = 8'h33; ram[10'h002] = 8'h44;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_flags", {mem_wr, fetch_done, load_done, store_done, mem_dout}, 32'h0);
    check("rst_data", fetch_inst | load_data, 32'h0);
    rst = 1'b0;
    #1;
    fetch_req = 1'b1; fetch_addr = 32'h100;
    run(10);
    check("fetch_lat", fd, 6);
    check("fetch_inst", fetch_inst, 32'h00000513);
    for (int i = 1; i <= 4; i++) check("fetch_addr_seq", a_log[i], 32'h100 + 32'(i - 1));
    check("fetch_no_wr", wcount(10), 0);
    load_req = 1'b1; load_addr = 32'h200; load_size = 2'b00; load_signed = 1'b1;
    run(6);
    check("lb_lat", ld, 3);
    check("lb_signed", load_data, 32'hFFFFFF80);
    load_req = 1'b1; load_signed = 1'b0;
    run(6);
    check("lbu_lat", ld, 3);
    check("lbu_data", load_data, 32'h00000080);
    load_req = 1'b1; load_addr = 32'h204; load_size = 2'b01; load_signed = 1'b1;
    run(7);
    check("lh_lat", ld, 4);
    check("lh_signed", load_data, 32'hFFFFF234);
    load_req = 1'b1; load_addr = 32'hFFFF_FFFF; load_size = 2'b10;
    run(9);
    check("lw_wrap_lat", ld, 6);
    check("lw_wrap_data", load_data, 32'h44332211);
    check("lw_wrap_a0", a_log[1], 32'hFFFF_FFFF);
    check("lw_wrap_a1", a_log[2], 32'h0);
`ifdef MEM_ARB_RR_EN
    e_ld = 12; e_fd = 9;
`else
    e_ld = 6; e_fd = 12;
`endif
    store_req = 1'b1; store_addr = 32'h300; store_size = 2'b01; store_data = 32'h0000BEEF;
    load_req = 1'b1; load_addr = 32'h200; load_size = 2'b00; load_signed = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h100;
    run(16);
    check("prio_store_lat", sd, 3);
    check("prio_load_lat", ld, e_ld);
    check("prio_fetch_lat", fd, e_fd);
    check("sh_bytes", {ram[10'h301], ram[10'h300]}, 32'hBEEF);
    check("sh_a0", a_log[1], 32'h300);
    check("sh_a1", a_log[2], 32'h301);
    check("sh_wr_cnt", wcount(16), 2);
    check("prio_load_data", load_data, 32'h80);
    store_req = 1'b1; store_addr = 32'h30000; store_size = 2'b00; store_data = 32'h41;
    io_buffer_full = 1'b1; io_rel = 5;
    run(12);
    check("io_wr_cnt", wcount(12), 1);
    check("io_wr_cycle", w_log[6], 1);
    check("io_wr_addr", a_log[6], 32'h30000);
    check("io_wr_byte", d_log[6], 32'h41);
    check("io_done_lat", sd, 7);
    store_req = 1'b1; store_addr = 32'h30010; store_size = 2'b01; store_data = 32'h5A6B;
    run(8);
    check("io_gap", w_log[2], 0);
    check("io_half_b1", d_log[3], 32'h5A);
    check("io_half_cnt", wcount(8), 2);
    check("io_half_lat", sd, 4);
    load_req = 1'b1; load_addr = 32'h100; load_size = 2'b10; clr_on = 3; clr_off = 4;
    run(12);
    check("clr_ld_none", ld, -1);
    check("clr_ld_addr_hold", a_log[5], 32'h102);
    store_req = 1'b1; store_addr = 32'h310; store_size = 2'b10; store_data = 32'hCAFEBABE;
    clr_on = 2; clr_off = 3;
    run(9);
    check("clr_sw_lat", sd, 5);
    check("clr_sw_cnt", wcount(9), 4);
    check("clr_sw_data", {ram[10'h313], ram[10'h312], ram[10'h311], ram[10'h310]}, 32'hCAFEBABE);
    fetch_req = 1'b1; fetch_addr = 32'h100; clear = 1'b1; clr_off = 1;
    run(10);
    check("clr_idle_fetch_lat", fd, 7);
    store_req = 1'b1; store_addr = 32'h330; store_size = 2'b00; store_data = 32'h77; clear = 1'b1; clr_off = 1;
    run(5);
    check("clr_idle_store_lat", sd, 2);
    check("clr_idle_store_byte", ram[10'h330], 32'h77);
    fetch_req = 1'b1; fetch_addr = 32'h100; rdy_off = 3; rdy_on = 6;
    run(12);
    check("rdy_fetch_lat", fd, 9);
    check("rdy_fetch_inst", fetch_inst, 32'h00000513);
    store_req = 1'b1; store_addr = 32'h320; store_size = 2'b10; store_data = 32'h12345678;
    rdy_off = 2; rdy_on = 5;
    run(11);
    check("rdy_sw_paused_wr", w_log[3], 0);
    check("rdy_sw_cnt", wcount(11), 4);
    check("rdy_sw_lat", sd, 8);
    check("rdy_sw_data", {ram[10'h323], ram[10'h322], ram[10'h321], ram[10'h320]}, 32'h12345678);
    store_req = 1'b1; store_addr = 32'h340; store_size = 2'b10; store_data = 32'h11223344;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_wr", mem_wr, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr", mem_wr, 0);
    check("mid_rst_a", mem_a, 32'h0);
    store_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    load_req = 1'b1; load_addr = 32'h200; load_size = 2'b00; load_signed = 1'b0;
    run(6);
    check("post_rst_load", ld, 3);
`ifdef MEM_ARB_RR_EN
    e_ld = 9; e_fd = 6;
`else
    e_ld = 3; e_fd = 9;
`endif
    load_req = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h100;
    run(12);
    check("lf_load_lat", ld, e_ld);
    check("lf_fetch_lat", fd, e_fd);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single byte-wide RAM/IO port between three requesters: instruction fetch (pc), load (ls buffer) and committed store (rob).
- Converts each word, half or byte request into byte-serial RAM cycles and reassembles little-endian read data with sign or zero extension.
- Handles UART back-pressure and pipeline flush.
- Sits between the pc/lsb/rob units and the top-level mem_* pins.

Parameters:
- ADDR_W, 32, address width of requests and mem_a
- DATA_W, 32, data width of fetch/load/store words
- IO_HI, 2'b11, value of addr[17:16] that marks the IO region

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rdy  in  1  when low, freeze all state; mem_wr forced 0
- clear  in  1  flush from rob; aborts fetch/load
- fetch_req  in  1  level request, held until fetch_done
- fetch_addr  in  32  instruction address
- fetch_done  out  1  one-cycle pulse, fetch_inst valid
- fetch_inst  out  32  assembled instruction
- load_req  in  1  level request
- load_addr  in  32  load address
- load_size  in  2  00 byte, 01 half, 10 word
- load_signed  in  1  sign-extend result
- load_done  out  1  one-cycle pulse
- load_data  out  32  extended load result
- store_req  in  1  level request
- store_addr  in  32  store address
- store_size  in  2  as load_size
- store_data  in  32  data; low bytes used
- store_done  out  1  one-cycle pulse
- io_buffer_full  in  1  UART full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write

Behaviour:
- Reset: state IDLE; all outputs, byte counter and assembly register 0.
- States: IDLE, READ, WRITE.
- Operand latching: addr, size and signed are latched at grant. Requesters hold req and operands until done.
- Arbitration in IDLE uses fixed priority store > load > fetch.
- A requester whose done is high in the current cycle is masked. This prevents re-grant before it drops req.
- Outputs mem_a, mem_wr and mem_dout are registered.
- Read of N bytes (N = 1/2/4):
  - Grant cycle 0.
  - mem_a = addr+k in cycle k+1.
  - Byte k sampled from mem_din in cycle k+2.
  - done visible in cycle N+2.
  - Then IDLE.
- Write of N bytes:
  - mem_wr = 1, mem_a = addr+k, mem_dout = store_data[8k+7:8k] in cycle k+1.
  - store_done visible in cycle N+1.
- Extension:
  - Half/byte reads are sign-extended from bit 15/7 when load_signed=1, else zero-extended.
  - Fetch is always a word.
- Address arithmetic wraps modulo 2^32.
- IO stores (addr[17:16]==IO_HI):
  - While io_buffer_full=1, issue no byte (mem_wr=0) and hold the counter.
  - After each IO byte written, insert one idle cycle, because the full flag lags by one cycle.
- clear:
  - During READ, return to IDLE next edge, with mem_wr=0 and no done pulse.
  - During WRITE, the store completes normally.
  - In IDLE, fetch and load are not granted that cycle; a pending store is still granted.
- rdy low: state, counter and outputs hold; mem_wr driven 0 while paused. Resume continues the same byte.
- Reset mid-operation: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: load and fetch alternate round-robin when both are requesting (last-granted of the two loses). Store keeps absolute priority.
- Undefined: fixed priority store > load > fetch.

Test Plan:
- Fetch, addr 0x100, RAM bytes 13 05 00 00 -> mem_a 0x100..0x103 in cycles 1-4; fetch_done cycle 6, fetch_inst=0x00000513.
- Signed byte load at 0x200 = 0x80 -> load_data 0xFFFFFF80; same with load_signed=0 -> 0x00000080; load_done cycle 3.
- Store half 0xBEEF to 0x300 with simultaneous load and fetch req -> store wins; writes EF@0x300, BE@0x301; store_done cycle 3; load granted next, then fetch.
- Store byte 0x41 to 0x30000 with io_buffer_full high 5 cycles -> mem_wr stays 0 during those cycles; single write after release; store_done follows.
- Word load in progress, clear asserted in cycle 3 -> IDLE next edge, no load_done; same clear during a word store -> all 4 bytes written, store_done pulses.
- rdy low 3 cycles mid word fetch -> mem_wr 0, counter frozen; fetch_inst still correct with done delayed exactly 3 cycles. MEM_ARB_RR_EN build: load+fetch held high -> grants alternate.
